// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with in-order fetch queue and branch redirect
module if_stage #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_inst,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic [PC_WIDTH-1:0]   jump,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = PTR_W + 4;
  localparam logic [INST_WIDTH-1:0] NOP     = INST_WIDTH'(32'h0000_0013);
  localparam logic [PC_WIDTH-1:0]   PC_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
  logic [CNT_W-1:0]      count_q, count_d, unfilled_q, unfilled_d;
  logic [DROP_W-1:0]     drop_q, drop_d, outstanding;
  logic [PC_WIDTH-1:0]   slot_pc_q     [DEPTH];
  logic [PC_WIDTH-1:0]   slot_pc_d     [DEPTH];
  logic [INST_WIDTH-1:0] slot_inst_q   [DEPTH];
  logic [INST_WIDTH-1:0] slot_inst_d   [DEPTH];
  logic                  slot_filled_q [DEPTH];
  logic                  slot_filled_d [DEPTH];
  logic                  accept, pop, fill;

  // Request valid depends only on state, never on this cycle's inputs
  assign imem_req_valid = reset && (count_q != CNT_W'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (count_q != '0) && slot_filled_q[head_q];
  assign inst           = inst_valid ? slot_inst_q[head_q] : NOP;
  assign inst_pc        = inst_valid ? slot_pc_q[head_q] : '0;

  always_comb begin
    pc_d          = pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fptr_d        = fptr_q;
    count_d       = count_q;
    unfilled_d    = unfilled_q;
    drop_d        = drop_q;
    slot_pc_d     = slot_pc_q;
    slot_inst_d   = slot_inst_q;
    slot_filled_d = slot_filled_q;
    outstanding   = '0;
    fill          = 1'b0;
    accept        = imem_req_valid && imem_req_ready;
    pop           = inst_valid && inst_ready;

    if (redirect) begin
      pc_d       = (redirect_pc + jump) & PC_MASK;
      head_d     = '0;
      tail_d     = '0;
      fptr_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
      for (int i = 0; i < DEPTH; i++) slot_filled_d[i] = 1'b0;
      // Every response still in flight is now stale, including one accepted this cycle
      outstanding = drop_q + DROP_W'(unfilled_q) + DROP_W'(accept);
      drop_d = (imem_resp_valid && outstanding != '0) ? outstanding - DROP_W'(1) : outstanding;
    end else begin
      if (imem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - DROP_W'(1);
        end else if (unfilled_q != '0) begin
          fill                  = 1'b1;
          slot_inst_d[fptr_q]   = imem_resp_inst;
          slot_filled_d[fptr_q] = 1'b1;
          fptr_d                = fptr_q + PTR_W'(1);
        end
      end
      if (pop) begin
        slot_filled_d[head_q] = 1'b0;
        head_d                = head_q + PTR_W'(1);
      end
      if (accept) begin
        slot_pc_d[tail_q]     = pc_q;
        slot_filled_d[tail_q] = 1'b0;
        tail_d                = tail_q + PTR_W'(1);
        pc_d                  = pc_q + PC_WIDTH'(4);
      end
      count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
      unfilled_d = unfilled_q + CNT_W'(accept) - CNT_W'(fill);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fptr_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]     <= '0;
        slot_inst_q[i]   <= '0;
        slot_filled_q[i] <= 1'b0;
      end
    end else begin
      pc_q          <= pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fptr_q        <= fptr_d;
      count_q       <= count_d;
      unfilled_q    <= unfilled_d;
      drop_q        <= drop_d;
      slot_pc_q     <= slot_pc_d;
      slot_inst_q   <= slot_inst_d;
      slot_filled_q <= slot_filled_d;
    end
  end

endmodule
